// File: rtl/elevator_pkg.sv
// Shared floor-controller types and the "calls above/below" helper.
// Defining FLOOR_CTRL_ESTOP_EN adds the HALT state for the emergency stop.
package elevator_pkg;
    localparam int NUM_FLOORS = 7;

    typedef logic [2:0]            floor_t;
    typedef logic [NUM_FLOORS-1:0] calls_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_DOOR_OPEN
`ifdef FLOOR_CTRL_ESTOP_EN
        , ST_HALT
`endif
    } state_t;

    // True when any call lies strictly above (up=1) or strictly below (up=0) floor f.
    function automatic logic calls_beyond(calls_t c, floor_t f, logic up);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (up ? (i > int'(f)) : (i < int'(f))) begin
                hit = hit | c[i];
            end
        end
        return hit;
    endfunction
endpackage

// File: rtl/move_timer.sv
// Loadable down-counter shared by travel and door dwell timing.
// Load wins over enable; the count holds at zero until reloaded.
module move_timer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/floor_controller.sv
// Seven-position elevator floor controller: latches calls, travels, dwells with the door open.
// Defining FLOOR_CTRL_ESTOP_EN adds the estop input and a HALT state that freezes progress.
module floor_controller
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 50,
    parameter int DOOR_CYCLES   = 100
) (
    input  logic       clk,
    input  logic       reset_n,
`ifdef FLOOR_CTRL_ESTOP_EN
    input  logic       estop,
`endif
    input  logic [6:0] req,
    output logic [2:0] currentFl,
    output logic [6:0] pending,
    output logic       moving,
    output logic       dir_up,
    output logic       door_open
);
    localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW      = $clog2(MAX_CYC);
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

    state_t  state_q, state_d, eff_state;
    floor_t  floor_q, floor_d, step_floor;
    calls_t  pending_q, pending_d, calls, remaining, clr;
    logic    dir_q, dir_d, moving_q, door_q;
    logic    ahead, behind, resolve;
    logic    tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0] tmr_val;
`ifdef FLOOR_CTRL_ESTOP_EN
    state_t  saved_q, saved_d;
`endif

    move_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        tmr_load  = 1'b0;
        tmr_val   = TRAVEL_LOAD;
        tmr_en    = 1'b0;
        clr       = '0;
        resolve   = 1'b0;
        eff_state = state_q;
`ifdef FLOOR_CTRL_ESTOP_EN
        saved_d = saved_q;
        // On the release edge the saved state does its normal work, so a halt costs exactly its length.
        if ((state_q == ST_HALT) && !estop) begin
            eff_state = saved_q;
        end
`endif
        calls      = pending_q | req;
        step_floor = floor_q;
        if (eff_state == ST_MOVE_UP) begin
            step_floor = floor_q + floor_t'(1);
        end else if (eff_state == ST_MOVE_DOWN) begin
            step_floor = floor_q - floor_t'(1);
        end
        // Direction decisions are taken from the floor the car is at (or just reached).
        remaining = calls & ~(calls_t'(1) << step_floor);
        ahead     = calls_beyond(remaining, step_floor, dir_q);
        behind    = calls_beyond(remaining, step_floor, !dir_q);

        case (eff_state)
            ST_IDLE: begin
                if (calls[floor_q]) begin
                    clr      = calls_t'(1) << floor_q;
                    state_d  = ST_DOOR_OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LOAD;
                end else if (pending_q != '0) begin
                    dir_d    = calls_beyond(pending_q, floor_q, 1'b1);
                    state_d  = dir_d ? ST_MOVE_UP : ST_MOVE_DOWN;
                    tmr_load = 1'b1;
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (tmr_zero) begin
                    floor_d = step_floor;
                    if (calls[step_floor]) begin
                        clr      = calls_t'(1) << step_floor;
                        state_d  = ST_DOOR_OPEN;
                        tmr_load = 1'b1;
                        tmr_val  = DOOR_LOAD;
                    end else begin
                        resolve = 1'b1;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_DOOR_OPEN: begin
                clr = calls_t'(1) << floor_q;
                if (req[floor_q]) begin
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LOAD;
                end else if (tmr_zero) begin
                    resolve = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: ;
        endcase

        if (resolve) begin
            if (ahead) begin
                state_d  = dir_q ? ST_MOVE_UP : ST_MOVE_DOWN;
                tmr_load = 1'b1;
                tmr_val  = TRAVEL_LOAD;
            end else if (behind) begin
                dir_d    = !dir_q;
                state_d  = !dir_q ? ST_MOVE_UP : ST_MOVE_DOWN;
                tmr_load = 1'b1;
                tmr_val  = TRAVEL_LOAD;
            end else begin
                state_d = ST_IDLE;
            end
        end

`ifdef FLOOR_CTRL_ESTOP_EN
        if (estop) begin
            state_d  = ST_HALT;
            floor_d  = floor_q;
            dir_d    = dir_q;
            tmr_load = 1'b0;
            tmr_en   = 1'b0;
            clr      = '0;
            if (state_q != ST_HALT) begin
                saved_d = state_q;
            end
        end
`endif
        pending_d = calls & ~clr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            floor_q   <= '0;
            pending_q <= '0;
            dir_q     <= 1'b1;
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            dir_q     <= dir_d;
            moving_q  <= (state_d == ST_MOVE_UP) || (state_d == ST_MOVE_DOWN);
            door_q    <= (state_d == ST_DOOR_OPEN);
        end
    end

`ifdef FLOOR_CTRL_ESTOP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            saved_q <= ST_IDLE;
        end else begin
            saved_q <= saved_d;
        end
    end
`endif

    assign currentFl = floor_q;
    assign pending   = pending_q;
    assign moving    = moving_q;
    assign dir_up    = dir_q;
    assign door_open = door_q;
endmodule

// File: tb/tb_floor_controller.sv
// Randomized scoreboard bench for floor_controller: a trip-level model predicts each door opening.
// FLOOR_CTRL_ESTOP_EN also enables the emergency-stop delay check.
module tb_floor_controller;
    localparam int TC = 4;
    localparam int DC = 6;

    typedef struct {
        int fl;
        int at;
        int dur;
    } door_ev_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] req;
    logic [2:0] currentFl;
    logic [6:0] pending;
    logic       moving, dir_up, door_open;
`ifdef FLOOR_CTRL_ESTOP_EN
    logic       estop = 1'b0;
`endif

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    door_ev_t exp_q[$];

    int m_cur;
    bit m_dir;
    int m_idle_at;
    int m_e0;

    bit       mon_prev;
    bit       mon_have;
    int       mon_open_at;
    int       mon_last_fl;
    int       mon_d;
    door_ev_t mon_ev;

    floor_controller #(.TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef FLOOR_CTRL_ESTOP_EN
        .estop     (estop),
`endif
        .req       (req),
        .currentFl (currentFl),
        .pending   (pending),
        .moving    (moving),
        .dir_up    (dir_up),
        .door_open (door_open)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic bit any_beyond(input bit [6:0] s, input int f, input bit up);
        for (int i = 0; i < 7; i++) begin
            if (s[i] && (up ? (i > f) : (i < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push_ev(input int fl, input int at, input int dur);
        door_ev_t ev;
        ev.fl = fl;
        ev.at = at;
        ev.dur = dur;
        exp_q.push_back(ev);
    endtask

    // Trip model: serve all calls ahead in the current direction, then reverse.
    task automatic plan_batch(input bit [6:0] mask);
        bit [6:0] s;
        bit [6:0] one;
        int start, tgt, cur0;
        one  = 7'd1;
        s    = mask;
        cur0 = m_cur;
        m_e0 = cyc + 1;
        if (s[m_cur]) begin
            push_ev(m_cur, m_e0, DC);
            s[m_cur] = 1'b0;
            start = m_e0 + DC;
            if (s != 0 && !any_beyond(s, m_cur, m_dir)) m_dir = !m_dir;
        end else begin
            start = m_e0 + 1;
            m_dir = any_beyond(s, m_cur, 1'b1);
        end
        while (s != 0) begin
            tgt = m_cur;
            if (m_dir) begin
                for (int i = 6; i > m_cur; i--) if (s[i]) tgt = i;
            end else begin
                for (int i = 0; i < m_cur; i++) if (s[i]) tgt = i;
            end
            if (tgt == m_cur) break;
            start = start + ((tgt > m_cur) ? (tgt - m_cur) : (m_cur - tgt)) * TC;
            push_ev(tgt, start, DC);
            s[tgt] = 1'b0;
            m_cur  = tgt;
            start  = start + DC;
            if (s != 0 && !any_beyond(s, m_cur, m_dir)) m_dir = !m_dir;
        end
        m_idle_at = start;
        req = mask;
        @(negedge clk);
        req = '0;
        check("pending_latched", int'(pending), int'(mask & ~(one << cur0)));
    endtask

    task automatic finish_batch();
        while (cyc < m_idle_at + 1) @(negedge clk);
        check("idle_moving", int'(moving), 0);
        check("idle_door", int'(door_open), 0);
        check("idle_pending", int'(pending), 0);
        check("idle_floor", int'(currentFl), m_cur);
        check("idle_dir", int'(dir_up), int'(m_dir));
        check("doors_missed", exp_q.size(), 0);
    endtask

    task automatic hold_call(input int n);
        bit [6:0] one;
        int e0;
        one = 7'd1;
        e0  = cyc + 1;
        push_ev(m_cur, e0, DC + n - 1);
        m_idle_at = e0 + n - 1 + DC;
        req = one << m_cur;
        repeat (n) @(negedge clk);
        req = '0;
        check("pending_during_dwell", int'(pending), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_floor"}, int'(currentFl), 0);
        check({tag, "_pending"}, int'(pending), 0);
        check({tag, "_moving"}, int'(moving), 0);
        check({tag, "_door"}, int'(door_open), 0);
        check({tag, "_dir"}, int'(dir_up), 1);
    endtask

`ifdef FLOOR_CTRL_ESTOP_EN
    task automatic estop_trip();
        bit [6:0] one;
        door_ev_t ev;
        int tgt;
        one = 7'd1;
        tgt = (m_cur < 6) ? m_cur + 1 : m_cur - 1;
        plan_batch(one << tgt);
        ev = exp_q.pop_back();
        ev.at = ev.at + 20;
        exp_q.push_back(ev);
        m_idle_at = m_idle_at + 20;
        @(negedge clk);
        estop = 1'b1;
        repeat (20) @(negedge clk);
        check("halt_moving", int'(moving), 0);
        check("halt_door", int'(door_open), 0);
        estop = 1'b0;
        finish_batch();
    endtask
`endif

    // Monitor: every door opening is matched against the next predicted event.
    initial begin
        mon_prev    = 1'b0;
        mon_have    = 1'b0;
        mon_last_fl = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_prev    = 1'b0;
                mon_have    = 1'b0;
                mon_last_fl = 0;
            end else begin
                if (door_open && !mon_prev) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL door_unexpected: opened at floor %0d cycle %0d, no opening required",
                                 currentFl, cyc);
                    end else begin
                        mon_ev = exp_q.pop_front();
                        check("door_floor", int'(currentFl), mon_ev.fl);
                        check("door_cycle", cyc, mon_ev.at);
                        mon_open_at = cyc;
                        mon_have    = 1'b1;
                    end
                end
                if (!door_open && mon_prev && mon_have) begin
                    check("door_dwell", cyc - mon_open_at, mon_ev.dur);
                    mon_have = 1'b0;
                end
                mon_d = int'(currentFl) - mon_last_fl;
                if (mon_d != 0) begin
                    check("floor_step", (mon_d < 0) ? -mon_d : mon_d, 1);
                    mon_last_fl = int'(currentFl);
                end
                mon_prev = door_open;
            end
        end
    end

    initial begin
        bit [6:0] m;
        reset_n = 1'b0;
        req     = '0;
        m_cur   = 0;
        m_dir   = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset_n = 1'b1;
        @(negedge clk);

        plan_batch(7'b0001000); finish_batch();
        plan_batch(7'b0100010); finish_batch();
        plan_batch(7'b1000000); finish_batch();
        plan_batch(7'b1000000); finish_batch();
        plan_batch(7'b0001000); finish_batch();
        hold_call(10);          finish_batch();

        repeat (16) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            m = 7'($urandom_range(1, 127));
            plan_batch(m);
            finish_batch();
        end

`ifdef FLOOR_CTRL_ESTOP_EN
        estop_trip();
`endif

        plan_batch(7'b0000001); finish_batch();
        plan_batch(7'b0010000);
        while (cyc < m_e0 + 2 * TC + 2) @(negedge clk);
        check("pre_reset_floor", int'(currentFl), 2);
        reset_n = 1'b0;
        #1;
        check_reset_state("midtravel_reset");
        exp_q.delete();
        m_cur = 0;
        m_dir = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4 * TC) @(negedge clk);
        check("post_reset_floor", int'(currentFl), 0);
        check("post_reset_pending", int'(pending), 0);
        check("post_reset_moving", int'(moving), 0);
        plan_batch(7'b0000100); finish_batch();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
